// File: rtl/sfifo_wr_gen.sv
// Write-side traffic generator: pushes an incrementing byte pattern into the sfifo write port.
// Optional sticky overflow error is built when SFIFO_WR_GEN_OVFL_CHK_EN is defined.
module sfifo_wr_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [CNT_W-1:0]  count,
  input  logic [GAP_W-1:0]  gap,
  input  logic              full,
  input  logic              overflow,
  output logic              w_en,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   wrCount_q, wrCount_d;
  logic [GAP_W-1:0]   gapR_q, gapR_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
  logic               wEn;
  logic               clrErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      din_q       <= '0;
      remaining_q <= '0;
      wrCount_q   <= '0;
      gapR_q      <= '0;
      gapCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      remaining_q <= remaining_d;
      wrCount_q   <= wrCount_d;
      gapR_q      <= gapR_d;
      gapCnt_q    <= gapCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    remaining_d = remaining_q;
    wrCount_d   = wrCount_q;
    gapR_d      = gapR_q;
    gapCnt_d    = gapCnt_q;
    clrErr      = 1'b0;
    // full gates the write in the same cycle so a full FIFO is never written
    wEn         = (state_q == WRITE) && !full;
    case (state_q)
      IDLE: begin
        if (start) begin
          din_d       = seed;
          remaining_d = count;
          gapR_d      = gap;
          wrCount_d   = '0;
          clrErr      = 1'b1;
          state_d     = (count == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (wEn) begin
          din_d       = din_q + DATA_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          wrCount_d   = wrCount_q + CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (gapR_q != '0) begin
            gapCnt_d = gapR_q;
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        gapCnt_d = gapCnt_q - GAP_W'(1);
        if (gapCnt_q == GAP_W'(1)) state_d = WRITE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign w_en     = wEn;
  assign din      = din_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_count = wrCount_q;

`ifdef SFIFO_WR_GEN_OVFL_CHK_EN
  logic err_q;

  // Sticky until reset or the next accepted start; does not affect the run
  always_ff @(posedge clk) begin
    if (rst)                      err_q <= 1'b0;
    else if (clrErr)              err_q <= 1'b0;
    else if (busy && overflow)    err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_ovfl;
  logic unused_clr;

  assign unused_ovfl = overflow;
  assign unused_clr  = clrErr;
  assign err         = 1'b0;
`endif

endmodule

// File: doc/sfifo_wr_gen.md
# sfifo_wr_gen

Synthesizable write-side traffic generator for the synchronous FIFO (`sfifo`). On a start pulse it pushes a programmable number of incrementing byte values into the FIFO write port. It honours `full`, inserts an optional idle gap between writes, and reports completion. It is the producer matching the incrementing-pattern read checker, so the FIFO can be exercised end-to-end in simulation and on silicon.

## Interface
- `DATA_W`, default 8: data width; pattern wraps modulo 2^DATA_W.
- `CNT_W`, default 16: width of the write count and progress counter.
- `GAP_W`, default 4: width of the inter-write gap field.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle request to begin a run; sampled only in IDLE.
- `seed`  in  DATA_W  first data value of a run; sampled with `start`.
- `count`  in  CNT_W  number of writes in the run; sampled with `start`.
- `gap`  in  GAP_W  idle cycles between accepted writes; sampled with `start`.
- `full`  in  1  FIFO full flag.
- `overflow`  in  1  FIFO overflow flag; used only with the macro.
- `w_en`  out  1  FIFO write enable.
- `din`  out  DATA_W  FIFO write data.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `wr_count`  out  CNT_W  writes accepted in the current or last run.
- `err`  out  1  sticky overflow error; tied 0 without the macro.

## Operation
- FSM states: IDLE, WRITE, GAP, DONE.
- IDLE, `start`=1:
  - Latch `seed` into `din`, `count` into `remaining`, `gap` into `gap_r`; clear `wr_count` and `err`.
  - Go to DONE if `count`==0, else to WRITE.
- `start` outside IDLE is ignored; latched parameters do not change.
- WRITE: `w_en` = ~`full` (combinational gate on a registered state bit). An accepted write is `w_en`=1 at a rising edge. On each accepted write:
  - `din` ← `din`+1, wrapping 2^DATA_W−1 → 0.
  - `remaining` ← `remaining`−1; `wr_count` ← `wr_count`+1.
  - Next state: DONE if `remaining` was 1; else GAP (gap counter loaded with `gap_r`) if `gap_r`≠0; else stay in WRITE.
- WRITE with `full`=1: `w_en`=0; `din`, `remaining` and the state hold, so no value is skipped or duplicated.
- GAP: `w_en`=0. Decrement the gap counter each cycle; go to WRITE when it reaches 0, giving exactly `gap_r` idle cycles.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy` = state ∈ {WRITE, GAP, DONE}.
- `din` holds its last value after a run, which is the value after the final write.
- Reset, including mid-run, on the next edge forces:
  - state IDLE, `w_en`=0, `din`=0, `busy`=0, `done`=0, `wr_count`=0, `err`=0.
  - The partial run is abandoned with no `done` pulse.

## Timing
- `start` sampled at edge N → first possible `w_en` is in cycle N+1, with `din`=`seed`.
- With `gap`=0 and `full`=0, writes are back-to-back: one per cycle for `count` cycles.
- Write period with gap `g` and `full` low is g+1 cycles.
- `done` is asserted in the cycle after the edge that accepted the last write.
- `count`=0: `done` in cycle N+1; `w_en` never asserted.
- `full` rising in the same cycle as a pending write blocks that write combinationally; the generator never writes into a full FIFO.

## Configuration
- Macro `SFIFO_WR_GEN_OVFL_CHK_EN`.
- Defined:
  - `err` sets on any edge where `overflow`=1 while `busy`=1.
  - `err` stays set until `rst` or the next accepted `start`.
  - `err` does not stop the run.
- Undefined: `overflow` is ignored and `err` is constant 0.

## Test plan
- Basic run: `seed`=0x75, `count`=4, `gap`=0, `full`=0 → `w_en` high 4 consecutive cycles with `din` 0x75, 0x76, 0x77, 0x78; `done` the next cycle; `wr_count`=4; `busy` low afterwards.
- Wrap: `seed`=0xFE, `count`=3 → `din` sequence 0xFE, 0xFF, 0x00; `wr_count`=3.
- Backpressure: `seed`=0x10, `count`=6, `full` forced high for 3 cycles after the 2nd write → `w_en` low for those 3 cycles, then 0x12…0x15 written with no gaps or repeats; `done` after the 6th write.
- Gap: `seed`=0x00, `count`=3, `gap`=2 → writes in cycles N+1, N+4, N+7; `done` in N+8.
- Edge cases:
  - `count`=0 → `done` in N+1, `w_en` never high.
  - `start` re-pulsed mid-run → ignored; run completes unchanged.
- Reset and overflow: assert `rst` after 2 of 5 writes → next cycle all outputs are at reset values and no `done` pulse appears. With `SFIFO_WR_GEN_OVFL_CHK_EN`, pulse `overflow` mid-run → `err`=1 until the next `start`. Without the macro → `err` stays 0.
